mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator side of the cache bus: accepts load/store requests from the pipeline memory stage, drives `chipSel`/`addr`/`dat`/`write` toward the cache, and samples `dat`/`miss` back. On a miss it backs off and reissues the same access until the cache hits or a retry limit is reached. The pipeline sees a valid/ready request port and a one-cycle response pulse.

## Interface
- `ADDR_W`, 8, cache address width
- `DATA_W`, 32, data width
- `MISS_WAIT`, 4, backoff cycles between a miss and the reissue (≥1)
- `MAX_RETRY`, 3, misses tolerated before error (≥1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  ADDR_W  access address
- `req_wdata`  in  DATA_W  store data
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  DATA_W  load data, valid with `resp_valid`
- `resp_err`  out  1  retry limit hit, valid with `resp_valid`
- `chipSel`  out  1  cache select
- `addr`  out  ADDR_W  cache address
- `dat`  inout  DATA_W  cache data bus
- `write`  out  1  cache write enable
- `miss`  in  1  cache miss indication

## Operation
- States: IDLE, ACCESS, BACKOFF.
- IDLE: `req_ready`=1, `chipSel`=0. `req_valid & req_ready` at an edge latches write/addr/wdata, clears retry count, goes to ACCESS.
- ACCESS: `chipSel`=1; `addr`, `write` from latched request; `dat` driven with latched wdata only when `write`=1, else high-Z. At the next edge, sample `miss` (and `dat` for loads):
  - `miss`=0: `resp_valid`=1 next cycle, `resp_rdata` = sampled `dat` (loads; holds previous value on stores), `resp_err`=0; go IDLE.
  - `miss`=1, retry count+1 < `MAX_RETRY`: increment count, load backoff counter with `MISS_WAIT`, go BACKOFF.
  - `miss`=1, retry count+1 == `MAX_RETRY`: `resp_valid`=1, `resp_err`=1; go IDLE.
- BACKOFF: `chipSel`=0, `write`=0, `dat` high-Z, `addr` holds. Counter decrements each edge; on the edge where it reaches 0, go ACCESS.
- Stores and loads take identical miss/retry paths.
- `req_ready`=0 outside IDLE; `req_*` ignored then.
- `dat` is never driven by this unit unless `chipSel & write`, so no bus contention with the cache's read drive.

## Timing
- Reset (async, immediate): state IDLE, `req_ready`=1, `chipSel`=0, `write`=0, `addr`=0, `dat` high-Z, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counters 0.
- Hit latency: accept at edge E0, bus active E0–E1, `resp_valid` high E1–E2. `req_ready` is high E1–E2, so a new request accepted at E2 gives one access per 2 cycles.
- Each miss adds 1 + `MISS_WAIT` cycles.
- Worst-case error response: `resp_valid` at `MAX_RETRY` + (`MAX_RETRY`−1)·`MISS_WAIT` cycles after accept.
- Reset mid-ACCESS/BACKOFF: request dropped, no response pulse.

## Configuration
- `MAU_STATS_EN` defined: adds outputs `hit_count` and `miss_count` (16-bit each, saturating at 0xFFFF, reset 0).
  - `hit_count` increments on each ACCESS edge with `miss`=0.
  - `miss_count` increments on each ACCESS edge with `miss`=1.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `mau_pkg`: state encoding (IDLE=2'd0, ACCESS=2'd1, BACKOFF=2'd2), default width constants.
- Sub-module `mau_backoff_ctr`: loadable down-counter with a zero flag, width clog2(`MISS_WAIT`+1).
- Tristate assignment lives in the top level.

## Test plan
Parameters for all scenarios: `MISS_WAIT`=2, `MAX_RETRY`=3.
- Store hit: req write addr=1 wdata=15, `miss`=0 → `dat`=15 and `write`=1 during ACCESS; `resp_valid` 1 cycle, `resp_err`=0.
- Load hit: req read addr=2, cache drives `dat`=14, `miss`=0 → `resp_rdata`=14 at E1; `dat` never driven by the unit.
- Load miss-then-hit: addr=34, `miss`=1 on first ACCESS and 0 on second → `chipSel` low exactly 2 cycles; `resp_valid` 4 cycles after accept with cache data.
- Retry exhaustion: `miss` held 1 → 3 ACCESS phases; `resp_valid` with `resp_err`=1 at cycle 7 after accept.
- Reset during BACKOFF: assert `reset` mid-backoff → all outputs at reset values asynchronously; no `resp_valid`; next request behaves normally.
- Back-to-back hits at addr 1, 2, 1 → responses at cycles 1, 3, 5. With `MAU_STATS_EN`, the miss-then-hit scenario gives `hit_count`=1, `miss_count`=1.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and default widths for the cache-bus memory access unit.
package mau_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      BACKOFF = 2'd2
   } mau_state_e;

   localparam int ADDR_W_DEF    = 8;
   localparam int DATA_W_DEF    = 32;
   localparam int MISS_WAIT_DEF = 4;
   localparam int MAX_RETRY_DEF = 3;
   localparam int STAT_W        = 16;

   function automatic logic [STAT_W-1:0] sat_inc(
      input logic [STAT_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mau_backoff_ctr.sv
// Loadable down-counter timing the pause between a cache miss and the reissue.
module mau_backoff_ctr #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero,
   output logic         expire
);

   logic [W-1:0] count;

   assign zero   = (count == '0);
   // High on the edge where the count steps from 1 to 0.
   assign expire = dec & (count == W'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !zero) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Cache-bus initiator with miss backoff and bounded retry.
// Optional MAU_STATS_EN adds saturating hit/miss counters.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MISS_WAIT = MISS_WAIT_DEF,
   parameter int MAX_RETRY = MAX_RETRY_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              chipSel,
   output logic [ADDR_W-1:0] addr,
   inout  wire  [DATA_W-1:0] dat,
   output logic              write,
   input  logic              miss
`ifdef MAU_STATS_EN
   ,
   output logic [STAT_W-1:0] hit_count,
   output logic [STAT_W-1:0] miss_count
`endif
);

   localparam int CW = $clog2(MISS_WAIT + 1);
   localparam int RW = $clog2(MAX_RETRY + 1);

   mau_state_e state, state_nxt;

   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [RW-1:0]     retry_q;

   logic accept;
   logic hit_done;
   logic err_done;
   logic retry_go;
   logic bo_dec;
   logic bo_zero;
   logic bo_expire;

   mau_backoff_ctr #(
      .W (CW)
   ) u_backoff (
      .clk      (clk),
      .reset    (reset),
      .load     (retry_go),
      .load_val (CW'(MISS_WAIT)),
      .dec      (bo_dec),
      .zero     (bo_zero),
      .expire   (bo_expire)
   );

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      hit_done  = 1'b0;
      err_done  = 1'b0;
      retry_go  = 1'b0;
      bo_dec    = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (!miss) begin
               hit_done  = 1'b1;
               state_nxt = IDLE;
            end else if (retry_q + 1'b1 == RW'(MAX_RETRY)) begin
               err_done  = 1'b1;
               state_nxt = IDLE;
            end else begin
               retry_go  = 1'b1;
               state_nxt = BACKOFF;
            end
         end
         BACKOFF: begin
            bo_dec = !bo_zero;
            if (bo_expire) begin
               state_nxt = ACCESS;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         retry_q <= '0;
      end else if (accept) begin
         write_q <= req_write;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         retry_q <= '0;
      end else if (retry_go) begin
         retry_q <= retry_q + 1'b1;
      end
   end

   // Stores leave the last load data visible on resp_rdata.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= hit_done | err_done;
         resp_err   <= err_done;
         if (hit_done && !write_q) begin
            resp_rdata <= dat;
         end
      end
   end

   assign req_ready = (state == IDLE);
   assign chipSel   = (state == ACCESS);
   assign write     = chipSel & write_q;
   assign addr      = addr_q;
   assign dat       = (chipSel & write) ? wdata_q : {DATA_W{1'bz}};

`ifdef MAU_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == ACCESS) begin
         if (miss) begin
            miss_count <= sat_inc(miss_count);
         end else begin
            hit_count <= sat_inc(hit_count);
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with MISS_WAIT=2, MAX_RETRY=3.
module tb_mem_access_unit;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int MW = 2;
   localparam int MR = 3;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid;
   logic [DW-1:0] resp_rdata;
   logic          resp_err;
   logic          chipSel;
   logic [AW-1:0] addr;
   wire  [DW-1:0] dat;
   logic          write;
   logic          miss;
`ifdef MAU_STATS_EN
   logic [15:0]   hit_count;
   logic [15:0]   miss_count;
`endif

   logic [DW-1:0] cache_q;
   int            miss_target;
   int            miss_used;
   int            cyc;
   int            n_total;
   int            n_pass;
   int            acc_cyc;
   int            resp_cyc;

   mem_access_unit #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .MISS_WAIT (MW),
      .MAX_RETRY (MR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .chipSel    (chipSel),
      .addr       (addr),
      .dat        (dat),
      .write      (write),
      .miss       (miss)
`ifdef MAU_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cache model: misses a set number of times per request, then hits.
   assign dat  = (chipSel && !write) ? cache_q : {DW{1'bz}};
   assign miss = chipSel && (miss_used < miss_target);

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         miss_used <= 0;
      end else if (req_valid && req_ready) begin
         miss_used <= 0;
      end else if (chipSel && miss) begin
         miss_used <= miss_used + 1;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] wdata;
      logic [DW-1:0] cdata;
      int            misses;
      int            exp_lat;
      int            exp_low;
      logic          exp_err;
      logic          chk_rdata;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_req(input vec_t v, input string tag);
      int lat;
      int low;
`ifdef MAU_STATS_EN
      logic [15:0] h0;
      logic [15:0] m0;
      h0 = hit_count;
      m0 = miss_count;
`endif
      req_write   = v.wr;
      req_addr    = v.a;
      req_wdata   = v.wdata;
      cache_q     = v.cdata;
      miss_target = v.misses;
      req_valid   = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      acc_cyc   = cyc;
      chk({tag, "_cs"}, DW'(chipSel), DW'(1));
      chk({tag, "_addr"}, DW'(addr), DW'(v.a));
      chk({tag, "_wr"}, DW'(write), DW'(v.wr));
      chk({tag, "_dat"}, dat, v.wr ? v.wdata : v.cdata);
      lat = 0;
      low = 0;
      while (!resp_valid && lat < 40) begin
         if (!chipSel) low++;
         @(posedge clk);
         #1;
         lat++;
      end
      resp_cyc = cyc;
      chk({tag, "_lat"}, DW'(lat), DW'(v.exp_lat));
      chk({tag, "_low"}, DW'(low), DW'(v.exp_low));
      chk({tag, "_err"}, DW'(resp_err), DW'(v.exp_err));
      chk({tag, "_rdy"}, DW'(req_ready), DW'(1));
      if (v.chk_rdata) begin
         chk({tag, "_rdata"}, resp_rdata, v.exp_rdata);
      end
`ifdef MAU_STATS_EN
      chk({tag, "_hitc"}, DW'(hit_count - h0), DW'(v.exp_err ? 0 : 1));
      chk({tag, "_missc"}, DW'(miss_count - m0),
          DW'(v.exp_low / MW + (v.exp_err ? 1 : 0)));
`endif
   endtask

   initial begin
      int rel0;
      int nresp;
      n_total     = 0;
      n_pass      = 0;
      cyc         = 0;
      cache_q     = '0;
      miss_target = 0;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      reset       = 1'b0;

      //        wr    addr   wdata     cdata     mis lat low err  chk  rdata
      vecs[0] = '{1'b1, 8'd1,  32'd15,   32'h0,    0,  1,  0, 1'b0, 1'b1, 32'h0};
      vecs[1] = '{1'b0, 8'd2,  32'hAA,   32'd14,   0,  1,  0, 1'b0, 1'b1, 32'd14};
      vecs[2] = '{1'b0, 8'd34, 32'h0,    32'h1234, 1,  4,  2, 1'b0, 1'b1, 32'h1234};
      vecs[3] = '{1'b1, 8'd5,  32'h55,   32'h0,    1,  4,  2, 1'b0, 1'b1, 32'h1234};
      vecs[4] = '{1'b0, 8'd7,  32'h0,    32'h77,   255, 7, 4, 1'b1, 1'b0, 32'h0};
      vecs[5] = '{1'b0, 8'd1,  32'h0,    32'hA1,   0,  1,  0, 1'b0, 1'b1, 32'hA1};
      vecs[6] = '{1'b0, 8'd2,  32'h0,    32'hB2,   0,  1,  0, 1'b0, 1'b1, 32'hB2};
      vecs[7] = '{1'b0, 8'd1,  32'h0,    32'hC3,   0,  1,  0, 1'b0, 1'b1, 32'hC3};
      vecs[8] = '{1'b1, 8'd3,  32'h3333, 32'h0,    0,  1,  0, 1'b0, 1'b1, 32'h0};

      #1 reset = 1'b1;
      #1;
      chk("rst_ready", DW'(req_ready), DW'(1));
      chk("rst_cs", DW'(chipSel), DW'(0));
      chk("rst_write", DW'(write), DW'(0));
      chk("rst_addr", DW'(addr), DW'(0));
      chk("rst_rv", DW'(resp_valid), DW'(0));
      chk("rst_rdata", resp_rdata, '0);
`ifdef MAU_STATS_EN
      chk("rst_hitc", DW'(hit_count), DW'(0));
      chk("rst_missc", DW'(miss_count), DW'(0));
`endif
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         run_req(vecs[i], $sformatf("v%0d", i));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_pulse", i), DW'(resp_valid), DW'(0));
      end

      // Back-to-back hits: responses 1, 3, 5 cycles after first accept.
      run_req(vecs[5], "b2b0");
      rel0 = acc_cyc;
      chk("b2b0_cyc", DW'(resp_cyc - rel0), DW'(1));
      run_req(vecs[6], "b2b1");
      chk("b2b1_cyc", DW'(resp_cyc - rel0), DW'(3));
      run_req(vecs[7], "b2b2");
      chk("b2b2_cyc", DW'(resp_cyc - rel0), DW'(5));

      // Reset while backing off drops the request.
      req_write   = 1'b0;
      req_addr    = 8'd9;
      miss_target = 255;
      req_valid   = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("bo_cs", DW'(chipSel), DW'(0));
      chk("bo_addr", DW'(addr), DW'(9));
      #2 reset = 1'b1;
      #1;
      chk("mid_ready", DW'(req_ready), DW'(1));
      chk("mid_cs", DW'(chipSel), DW'(0));
      chk("mid_write", DW'(write), DW'(0));
      chk("mid_addr", DW'(addr), DW'(0));
      chk("mid_rv", DW'(resp_valid), DW'(0));
      chk("mid_err", DW'(resp_err), DW'(0));
      chk("mid_rdata", resp_rdata, '0);
      @(posedge clk);
      #1 reset = 1'b0;
      nresp = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (resp_valid) nresp++;
      end
      chk("mid_noresp", DW'(nresp), DW'(0));
      run_req(vecs[8], "post");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
